// File: rtl/calc2_port_sequencer.sv
// calc2 port sequencer: splits whole commands into the two-cycle calc2
// request protocol, tracks tags in flight and synthesises timeouts.
module calc2_port_sequencer #(
  parameter int TIMEOUT         = 64,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic        c_clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  req_cmd,
  input  logic [31:0] req_op1,
  input  logic [31:0] req_op2,
  output logic [1:0]  req_tag,
  output logic [3:0]  calc_cmd,
  output logic [31:0] calc_data,
  output logic [1:0]  calc_tag,
  input  logic [1:0]  calc_resp,
  input  logic [31:0] calc_rdata,
  input  logic [1:0]  calc_rtag,
  output logic        rsp_valid,
  output logic [1:0]  rsp_code,
  output logic [31:0] rsp_data,
  output logic [1:0]  rsp_tag,
  output logic        err_spurious,
  output logic [2:0]  outstanding
);

  typedef enum logic [1:0] {IDLE, P1, P2} state_e;

  localparam logic [9:0] TMO  = 10'(TIMEOUT);
  localparam logic [9:0] TLIM = 10'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [3:0]  ccmd_q, ccmd_d;
  logic [31:0] cdata_q, cdata_d;
  logic [1:0]  ctag_q, ctag_d;
  logic [31:0] op2_q, op2_d;
  logic [1:0]  itag_q, itag_d;
  logic [3:0]  infl_q, infl_d;
  logic [9:0]  cnt_q [4];
  logic [9:0]  cnt_d [4];
  logic        rv_q, rv_d;
  logic [1:0]  rc_q, rc_d;
  logic [31:0] rd_q, rd_d;
  logic [1:0]  rt_q, rt_d;
  logic        spur_q, spur_d;

  logic        free_any;
  logic [1:0]  alloc;
  logic        accept;
  logic        hit;
  logic [3:0]  expd;
  logic        exp_any;
  logic [1:0]  exp_tag;
  logic [3:0]  freed;

  always_comb begin
    free_any = 1'b0;
    alloc    = '0;
    for (int i = MAX_OUTSTANDING - 1; i >= 0; i--) begin
      if (!infl_q[i]) begin
        free_any = 1'b1;
        alloc    = 2'(i);
      end
    end
    expd = '0;
    for (int i = 0; i < MAX_OUTSTANDING; i++) begin
      expd[i] = infl_q[i] && (cnt_q[i] >= TLIM);
    end
    exp_any = 1'b0;
    exp_tag = '0;
    for (int i = 3; i >= 0; i--) begin
      if (expd[i]) begin
        exp_any = 1'b1;
        exp_tag = 2'(i);
      end
    end
  end

  assign req_ready = !reset && free_any &&
                     (state_q == IDLE || state_q == P2);
  assign req_tag   = alloc;
  assign accept    = req_valid && req_ready;
  assign hit       = (calc_resp != 2'd0) && infl_q[calc_rtag];

  // Real responses own the rsp port; expired tags wait (saturated).
  always_comb begin
    rv_d   = 1'b0;
    rc_d   = '0;
    rd_d   = '0;
    rt_d   = '0;
    freed  = '0;
    spur_d = (calc_resp != 2'd0) && !infl_q[calc_rtag];
    if (hit) begin
      rv_d             = 1'b1;
      rc_d             = calc_resp;
      rd_d             = calc_rdata;
      rt_d             = calc_rtag;
      freed[calc_rtag] = 1'b1;
    end else if (exp_any) begin
      rv_d           = 1'b1;
      rc_d           = 2'd3;
      rt_d           = exp_tag;
      freed[exp_tag] = 1'b1;
    end
    infl_d = infl_q & ~freed;
    if (accept) infl_d[alloc] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cnt_d[i] = cnt_q[i];
      if (infl_q[i] && cnt_q[i] != TMO)
        cnt_d[i] = cnt_q[i] + 10'd1;
      if (accept && alloc == 2'(i))
        cnt_d[i] = '0;
    end
  end

  always_comb begin
    state_d = state_q;
    ccmd_d  = '0;
    cdata_d = '0;
    ctag_d  = '0;
    op2_d   = op2_q;
    itag_d  = itag_q;
    unique case (state_q)
      IDLE, P2: begin
        if (accept) begin
          state_d = P1;
          ccmd_d  = req_cmd;
          cdata_d = req_op1;
          ctag_d  = alloc;
          op2_d   = req_op2;
          itag_d  = alloc;
        end else begin
          state_d = IDLE;
        end
      end
      P1: begin
        state_d = P2;
        cdata_d = op2_q;
        ctag_d  = itag_q;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge c_clk) begin
    if (reset) begin
      state_q <= IDLE;
      ccmd_q  <= '0;
      cdata_q <= '0;
      ctag_q  <= '0;
      op2_q   <= '0;
      itag_q  <= '0;
      infl_q  <= '0;
      for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
      rv_q    <= 1'b0;
      rc_q    <= '0;
      rd_q    <= '0;
      rt_q    <= '0;
      spur_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ccmd_q  <= ccmd_d;
      cdata_q <= cdata_d;
      ctag_q  <= ctag_d;
      op2_q   <= op2_d;
      itag_q  <= itag_d;
      infl_q  <= infl_d;
      for (int i = 0; i < 4; i++) cnt_q[i] <= cnt_d[i];
      rv_q    <= rv_d;
      rc_q    <= rc_d;
      rd_q    <= rd_d;
      rt_q    <= rt_d;
      spur_q  <= spur_d;
    end
  end

  assign calc_cmd     = ccmd_q;
  assign calc_data    = cdata_q;
  assign calc_tag     = ctag_q;
  assign rsp_valid    = rv_q;
  assign rsp_code     = rc_q;
  assign rsp_data     = rd_q;
  assign rsp_tag      = rt_q;
  assign err_spurious = spur_q;
  assign outstanding  = 3'($countones(infl_q));

endmodule

// File: tb/tb_calc2_port_sequencer.sv
// Directed bench for calc2_port_sequencer: per-cycle vector table
// followed by hand sequences for tag exhaustion, timeout and reset.
module tb_calc2_port_sequencer;

  logic        c_clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_cmd;
  logic [31:0] req_op1;
  logic [31:0] req_op2;
  logic [1:0]  req_tag;
  logic [3:0]  calc_cmd;
  logic [31:0] calc_data;
  logic [1:0]  calc_tag;
  logic [1:0]  calc_resp;
  logic [31:0] calc_rdata;
  logic [1:0]  calc_rtag;
  logic        rsp_valid;
  logic [1:0]  rsp_code;
  logic [31:0] rsp_data;
  logic [1:0]  rsp_tag;
  logic        err_spurious;
  logic [2:0]  outstanding;

  int pass_cnt = 0;
  int total    = 0;

  calc2_port_sequencer #(.TIMEOUT(16), .MAX_OUTSTANDING(4)) dut (
    .c_clk(c_clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_cmd(req_cmd), .req_op1(req_op1), .req_op2(req_op2),
    .req_tag(req_tag),
    .calc_cmd(calc_cmd), .calc_data(calc_data), .calc_tag(calc_tag),
    .calc_resp(calc_resp), .calc_rdata(calc_rdata),
    .calc_rtag(calc_rtag),
    .rsp_valid(rsp_valid), .rsp_code(rsp_code),
    .rsp_data(rsp_data), .rsp_tag(rsp_tag),
    .err_spurious(err_spurious), .outstanding(outstanding)
  );

  always #5 c_clk = ~c_clk;

  typedef struct {
    logic        v;
    logic [3:0]  cmd;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [1:0]  resp;
    logic [31:0] rdata;
    logic [1:0]  rtag;
    logic        e_rdy;
    logic [1:0]  e_tag;
    logic [3:0]  e_ccmd;
    logic [31:0] e_cdata;
    logic [1:0]  e_ctag;
    logic        e_rv;
    logic [1:0]  e_rc;
    logic [31:0] e_rd;
    logic [1:0]  e_rt;
    logic        e_spur;
    logic [2:0]  e_out;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic nc();
    @(negedge c_clk);
    #1;
  endtask

  task automatic do_accept(input logic [3:0] c, input logic [31:0] a,
                           input logic [31:0] b, input logic [1:0] et,
                           input int ew, input string nm);
    int n;
    req_valid = 1'b1;
    req_cmd   = c;
    req_op1   = a;
    req_op2   = b;
    #1;
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge c_clk);
      #1;
      n++;
    end
    chk({nm, " ready"}, 32'(req_ready), 32'd1);
    chk({nm, " tag"}, 32'(req_tag), 32'(et));
    if (ew >= 0) chk({nm, " wait"}, 32'(n), 32'(ew));
    @(negedge c_clk);
    req_valid = 1'b0;
    #1;
  endtask

  initial begin
    int k;
    vecs[0] = '{1'b1, 4'd1, 32'd5, 32'd3, 2'd0, 32'd0, 2'd0,
                1'b1, 2'd0, 4'd0, 32'd0, 2'd0,
                1'b0, 2'd0, 32'd0, 2'd0, 1'b0, 3'd0};
    vecs[1] = '{1'b0, 4'd0, 32'd0, 32'd0, 2'd0, 32'd0, 2'd0,
                1'b0, 2'd1, 4'd1, 32'd5, 2'd0,
                1'b0, 2'd0, 32'd0, 2'd0, 1'b0, 3'd1};
    vecs[2] = '{1'b0, 4'd0, 32'd0, 32'd0, 2'd0, 32'd0, 2'd0,
                1'b1, 2'd1, 4'd0, 32'd3, 2'd0,
                1'b0, 2'd0, 32'd0, 2'd0, 1'b0, 3'd1};
    vecs[3] = '{1'b0, 4'd0, 32'd0, 32'd0, 2'd1, 32'd8, 2'd0,
                1'b1, 2'd1, 4'd0, 32'd0, 2'd0,
                1'b0, 2'd0, 32'd0, 2'd0, 1'b0, 3'd1};
    vecs[4] = '{1'b0, 4'd0, 32'd0, 32'd0, 2'd0, 32'd0, 2'd0,
                1'b1, 2'd0, 4'd0, 32'd0, 2'd0,
                1'b1, 2'd1, 32'd8, 2'd0, 1'b0, 3'd0};
    vecs[5] = '{1'b0, 4'd0, 32'd0, 32'd0, 2'd1, 32'h55, 2'd3,
                1'b1, 2'd0, 4'd0, 32'd0, 2'd0,
                1'b0, 2'd0, 32'd0, 2'd0, 1'b0, 3'd0};
    vecs[6] = '{1'b0, 4'd0, 32'd0, 32'd0, 2'd0, 32'd0, 2'd0,
                1'b1, 2'd0, 4'd0, 32'd0, 2'd0,
                1'b0, 2'd0, 32'd0, 2'd0, 1'b1, 3'd0};
    vecs[7] = '{1'b0, 4'd0, 32'd0, 32'd0, 2'd0, 32'd0, 2'd0,
                1'b1, 2'd0, 4'd0, 32'd0, 2'd0,
                1'b0, 2'd0, 32'd0, 2'd0, 1'b0, 3'd0};

    reset = 1'b1;
    req_valid = 1'b0;
    req_cmd = '0;
    req_op1 = '0;
    req_op2 = '0;
    calc_resp = '0;
    calc_rdata = '0;
    calc_rtag = '0;
    nc();
    nc();
    chk("rst calc_cmd", 32'(calc_cmd), 32'd0);
    chk("rst calc_data", calc_data, 32'd0);
    chk("rst rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst spurious", 32'(err_spurious), 32'd0);
    chk("rst outstanding", 32'(outstanding), 32'd0);
    chk("rst req_ready", 32'(req_ready), 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 8; i++) begin
      @(negedge c_clk);
      req_valid  = vecs[i].v;
      req_cmd    = vecs[i].cmd;
      req_op1    = vecs[i].op1;
      req_op2    = vecs[i].op2;
      calc_resp  = vecs[i].resp;
      calc_rdata = vecs[i].rdata;
      calc_rtag  = vecs[i].rtag;
      #1;
      chk($sformatf("v%0d ready", i), 32'(req_ready), 32'(vecs[i].e_rdy));
      if (vecs[i].e_rdy)
        chk($sformatf("v%0d req_tag", i), 32'(req_tag), 32'(vecs[i].e_tag));
      chk($sformatf("v%0d calc_cmd", i), 32'(calc_cmd), 32'(vecs[i].e_ccmd));
      chk($sformatf("v%0d calc_data", i), calc_data, vecs[i].e_cdata);
      chk($sformatf("v%0d calc_tag", i), 32'(calc_tag), 32'(vecs[i].e_ctag));
      chk($sformatf("v%0d rsp_valid", i), 32'(rsp_valid), 32'(vecs[i].e_rv));
      if (vecs[i].e_rv) begin
        chk($sformatf("v%0d rsp_code", i), 32'(rsp_code), 32'(vecs[i].e_rc));
        chk($sformatf("v%0d rsp_data", i), rsp_data, vecs[i].e_rd);
        chk($sformatf("v%0d rsp_tag", i), 32'(rsp_tag), 32'(vecs[i].e_rt));
      end
      chk($sformatf("v%0d spurious", i), 32'(err_spurious), 32'(vecs[i].e_spur));
      chk($sformatf("v%0d outstanding", i), 32'(outstanding), 32'(vecs[i].e_out));
    end
    req_valid = 1'b0;
    calc_resp = '0;

    // four back-to-back accepts exhaust the tags
    do_accept(4'd1, 32'd10, 32'd11, 2'd0, 0, "bb0");
    do_accept(4'd2, 32'd20, 32'd21, 2'd1, 1, "bb1");
    chk("bb1 calc_tag", 32'(calc_tag), 32'd1);
    chk("bb1 calc_cmd", 32'(calc_cmd), 32'd2);
    do_accept(4'd5, 32'd30, 32'd31, 2'd2, 1, "bb2");
    do_accept(4'd6, 32'd40, 32'd41, 2'd3, 1, "bb3");
    nc();
    chk("full ready", 32'(req_ready), 32'd0);
    chk("full outstanding", 32'(outstanding), 32'd4);
    calc_resp  = 2'd1;
    calc_rdata = 32'd7;
    calc_rtag  = 2'd2;
    nc();
    calc_resp = '0;
    chk("t2 rsp_valid", 32'(rsp_valid), 32'd1);
    chk("t2 rsp_tag", 32'(rsp_tag), 32'd2);
    chk("t2 rsp_data", rsp_data, 32'd7);
    chk("t2 outstanding", 32'(outstanding), 32'd3);
    do_accept(4'd1, 32'd1, 32'd2, 2'd2, 0, "reuse2");
    reset = 1'b1;
    nc();
    chk("rst4 outstanding", 32'(outstanding), 32'd0);
    chk("rst4 calc_cmd", 32'(calc_cmd), 32'd0);
    reset = 1'b0;
    nc();

    // timeout exactly 16 cycles after P1, then a late response
    do_accept(4'd2, 32'd9, 32'd4, 2'd0, 0, "to");
    k = 0;
    for (int n = 1; n <= 30; n++) begin
      nc();
      if (rsp_valid) begin
        k = n;
        break;
      end
    end
    chk("to latency", 32'(k), 32'd16);
    chk("to rsp_code", 32'(rsp_code), 32'd3);
    chk("to rsp_data", rsp_data, 32'd0);
    chk("to rsp_tag", 32'(rsp_tag), 32'd0);
    chk("to outstanding", 32'(outstanding), 32'd0);
    calc_resp  = 2'd1;
    calc_rdata = 32'd1;
    calc_rtag  = 2'd0;
    nc();
    calc_resp = '0;
    chk("late spurious", 32'(err_spurious), 32'd1);
    chk("late rsp_valid", 32'(rsp_valid), 32'd0);
    nc();
    chk("late spurious off", 32'(err_spurious), 32'd0);

    // real response collides with a timeout expiry
    do_accept(4'd1, 32'd1, 32'd1, 2'd0, 0, "col0");
    do_accept(4'd5, 32'd2, 32'd3, 2'd1, 1, "col1");
    for (int n = 0; n < 13; n++) nc();
    calc_resp  = 2'd2;
    calc_rdata = 32'hDEAD;
    calc_rtag  = 2'd1;
    nc();
    calc_resp = '0;
    chk("col a valid", 32'(rsp_valid), 32'd1);
    chk("col a code", 32'(rsp_code), 32'd2);
    chk("col a tag", 32'(rsp_tag), 32'd1);
    chk("col a data", rsp_data, 32'hDEAD);
    nc();
    chk("col b valid", 32'(rsp_valid), 32'd1);
    chk("col b code", 32'(rsp_code), 32'd3);
    chk("col b tag", 32'(rsp_tag), 32'd0);
    chk("col b data", rsp_data, 32'd0);
    nc();
    chk("col c valid", 32'(rsp_valid), 32'd0);
    chk("col c outstanding", 32'(outstanding), 32'd0);

    // reset during P1 with two tags in flight
    do_accept(4'd1, 32'd3, 32'd4, 2'd0, 0, "r0");
    do_accept(4'd2, 32'd5, 32'd6, 2'd1, 1, "r1");
    chk("r pre outstanding", 32'(outstanding), 32'd2);
    reset = 1'b1;
    nc();
    chk("r calc_cmd", 32'(calc_cmd), 32'd0);
    chk("r calc_data", calc_data, 32'd0);
    chk("r calc_tag", 32'(calc_tag), 32'd0);
    chk("r outstanding", 32'(outstanding), 32'd0);
    chk("r rsp_valid", 32'(rsp_valid), 32'd0);
    chk("r ready", 32'(req_ready), 32'd0);
    reset = 1'b0;
    nc();
    do_accept(4'd6, 32'h77, 32'h2, 2'd0, 0, "post");
    chk("post calc_cmd", 32'(calc_cmd), 32'd6);
    chk("post calc_data", calc_data, 32'h77);
    chk("post rsp_valid", 32'(rsp_valid), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
